// File: rtl/snax_alu_pkg.sv
// ============================================================================
// Module      : snax_alu_pkg
// Description : Shared types and default sizes for the SNAX ALU processing
//               element, its CSR manager and the result packer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package snax_alu_pkg;

  // Default result width and packing ratio shared across the ALU cluster.
  localparam int unsigned DefaultDataWidth  = 64;
  localparam int unsigned DefaultPackFactor = 4;

  // Result packer control states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2
  } packer_state_e;

endpackage : snax_alu_pkg

`default_nettype wire

// File: rtl/snax_alu_result_packer.sv
// ============================================================================
// Module      : snax_alu_result_packer
// Description : Packs PackFactor consecutive ALU results into one wide word
//               with a per-lane strobe, flushes a partial final word and
//               pulses done_o once the last word has left the block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module snax_alu_result_packer
  import snax_alu_pkg::*;
#(
  parameter int unsigned DataWidth  = DefaultDataWidth,
  parameter int unsigned PackFactor = DefaultPackFactor,
  parameter int unsigned CountWidth = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             start_i,
  input  logic [CountWidth-1:0]            len_i,
  input  logic [DataWidth-1:0]             res_i,
  input  logic                             res_valid_i,
  output logic                             res_ready_o,
  output logic [DataWidth*PackFactor-1:0]  pack_o,
  output logic [PackFactor-1:0]            pack_strb_o,
  output logic                             pack_valid_o,
  input  logic                             pack_ready_i,
  output logic                             busy_o,
  output logic                             done_o
);

  localparam int unsigned LaneWidth = $clog2(PackFactor);
  localparam int unsigned PackWidth = DataWidth * PackFactor;

  packer_state_e          state_q, state_d;
  logic [CountWidth-1:0]  len_q, cnt_q;
  logic [LaneWidth-1:0]   lane_q;
  logic [PackWidth-1:0]   fill_q, fill_merged;
  logic [PackFactor-1:0]  mask_q, mask_merged;
  logic [PackWidth-1:0]   pack_q;
  logic [PackFactor-1:0]  strb_q;
  logic                   pvalid_q;
  logic                   done_q, done_d;

  logic accept, last, word_done, out_hs, start_run;

  // Stall the PE only while the output register is full and not draining.
  assign res_ready_o = (state_q == COLLECT) && !(pvalid_q && !pack_ready_i);
  assign accept      = res_valid_i && res_ready_o;
  assign last        = (cnt_q == len_q - CountWidth'(1));
  assign word_done   = accept && ((lane_q == LaneWidth'(PackFactor - 1)) || last);
  assign out_hs      = pvalid_q && pack_ready_i;
  assign start_run   = (state_q == IDLE) && start_i && (len_i != '0);

  assign pack_o       = pack_q;
  assign pack_strb_o  = strb_q;
  assign pack_valid_o = pvalid_q;
  assign busy_o       = (state_q != IDLE);
  assign done_o       = done_q;

  // Fill buffer and mask as they look with the incoming result merged in,
  // so a completing word can be moved to the output in the same cycle.
  always_comb begin
    fill_merged = fill_q;
    mask_merged = mask_q;
    for (int k = 0; k < PackFactor; k++) begin
      if (lane_q == LaneWidth'(k)) begin
        fill_merged[k*DataWidth +: DataWidth] = res_i;
        mask_merged[k]                        = 1'b1;
      end
    end
  end

  // Next-state and completion-pulse decode.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (len_i != '0) state_d = COLLECT;
          else             done_d  = 1'b1;
        end
      end
      COLLECT: begin
        if (accept && last) state_d = DRAIN;
      end
      DRAIN: begin
        if (out_hs) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register and registered done pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // Run length and progress counters; the lane index wraps naturally
  // because PackFactor is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      len_q  <= '0;
      cnt_q  <= '0;
      lane_q <= '0;
    end else if (start_run) begin
      len_q  <= len_i;
      cnt_q  <= '0;
      lane_q <= '0;
    end else if (accept) begin
      cnt_q  <= cnt_q + CountWidth'(1);
      lane_q <= lane_q + LaneWidth'(1);
    end
  end

  // Fill buffer: accumulate lanes, restart from zero after each word so
  // unused lanes of a partial final word read as zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fill_q <= '0;
      mask_q <= '0;
    end else if (start_run || word_done) begin
      fill_q <= '0;
      mask_q <= '0;
    end else if (accept) begin
      fill_q <= fill_merged;
      mask_q <= mask_merged;
    end
  end

  // Output register: a new word wins over a simultaneous drain; a drain
  // with no new word clears the register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pack_q   <= '0;
      strb_q   <= '0;
      pvalid_q <= 1'b0;
    end else if (word_done) begin
      pack_q   <= fill_merged;
      strb_q   <= mask_merged;
      pvalid_q <= 1'b1;
    end else if (out_hs) begin
      pack_q   <= '0;
      strb_q   <= '0;
      pvalid_q <= 1'b0;
    end
  end

endmodule : snax_alu_result_packer

`default_nettype wire

// File: tb/tb_snax_alu_result_packer.sv
// ============================================================================
// Module      : tb_snax_alu_result_packer
// Description : Self-checking bench for snax_alu_result_packer with a
//               chunk-and-pad reference model of the packed output stream.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_snax_alu_result_packer;

  localparam int DW = 64;
  localparam int PF = 4;
  localparam int CW = 16;
  localparam int PW = DW * PF;

  logic          clk_i       = 1'b0;
  logic          rst_ni      = 1'b0;
  logic          start_i     = 1'b0;
  logic [CW-1:0] len_i       = '0;
  logic [DW-1:0] res_i       = '0;
  logic          res_valid_i = 1'b0;
  logic          res_ready_o;
  logic [PW-1:0] pack_o;
  logic [PF-1:0] pack_strb_o;
  logic          pack_valid_o;
  logic          pack_ready_i = 1'b0;
  logic          busy_o;
  logic          done_o;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] stim[$];
  logic [PW-1:0] got_data[$];
  logic [PF-1:0] got_strb[$];
  int            done_cnt    = 0;
  int            stall_cnt   = 0;
  logic          prev_stall  = 1'b0;
  logic [PW-1:0] prev_pack   = '0;
  logic [PF-1:0] prev_strb   = '0;

  snax_alu_result_packer #(
    .DataWidth (DW),
    .PackFactor(PF),
    .CountWidth(CW)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .len_i       (len_i),
    .res_i       (res_i),
    .res_valid_i (res_valid_i),
    .res_ready_o (res_ready_o),
    .pack_o      (pack_o),
    .pack_strb_o (pack_strb_o),
    .pack_valid_o(pack_valid_o),
    .pack_ready_i(pack_ready_i),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: results are chopped into groups of PF, lane k holds
  // result w*PF+k, lanes past the run length are zero with strobe 0.
  function automatic logic [PW-1:0] exp_word(input int w, input int len);
    logic [PW-1:0] r;
    r = '0;
    for (int k = 0; k < PF; k++)
      if (w * PF + k < len) r[k*DW +: DW] = stim[w*PF+k];
    return r;
  endfunction

  function automatic logic [PF-1:0] exp_strb(input int w, input int len);
    logic [PF-1:0] r;
    r = '0;
    for (int k = 0; k < PF; k++)
      if (w * PF + k < len) r[k] = 1'b1;
    return r;
  endfunction

  // Output-side observer: records handshakes and done pulses, and checks
  // the stall/idle output invariants every cycle.
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      prev_stall = 1'b0;
    end else begin
      if (done_o) done_cnt++;
      if (!pack_valid_o) begin
        checks++;
        if (pack_o !== '0 || pack_strb_o !== '0) begin
          errors++;
          $display("FAIL idle_out_zero: pack_o=%h strb=%b, required all zero", pack_o, pack_strb_o);
        end
      end
      if (prev_stall) begin
        checks++;
        if (pack_valid_o !== 1'b1 || pack_o !== prev_pack || pack_strb_o !== prev_strb) begin
          errors++;
          $display("FAIL stall_hold: valid=%b pack_o=%h strb=%b, required 1 %h %b",
                   pack_valid_o, pack_o, pack_strb_o, prev_pack, prev_strb);
        end
      end
      if (pack_valid_o && !pack_ready_i) begin
        stall_cnt++;
        checks++;
        if (res_ready_o !== 1'b0) begin
          errors++;
          $display("FAIL stall_res_ready: res_ready_o=%b, required 0", res_ready_o);
        end
      end
      if (pack_valid_o && pack_ready_i) begin
        got_data.push_back(pack_o);
        got_strb.push_back(pack_strb_o);
      end
      prev_stall = pack_valid_o && !pack_ready_i;
      prev_pack  = pack_o;
      prev_strb  = pack_strb_o;
    end
  end

  // Drives one run from start to done. ready_mode: 0 always ready,
  // 1 random, 2 five stall cycles once the first word appears.
  task automatic run_stream(input int len, input int ready_mode, input bit gaps, input bit inject,
                            output int acc_cycles, output int n_acc, output bit timed_out);
    int dbase, cyc, stall_left;
    bit exp_valid, injected;
    dbase = done_cnt; cyc = 0; stall_left = 5; exp_valid = 0; injected = 0;
    n_acc = 0; acc_cycles = 0;
    got_data.delete(); got_strb.delete();
    start_i = 1'b1; len_i = CW'(len); res_valid_i = 1'b0; pack_ready_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0; len_i = CW'($urandom);
    while (done_cnt == dbase && cyc < 3000) begin
      start_i = 1'b0;
      if (inject && !injected && n_acc == 2) begin
        start_i = 1'b1; len_i = CW'(2); injected = 1;
      end
      res_valid_i = (n_acc < len) ? (gaps ? ($urandom_range(0, 3) != 0) : 1'b1) : 1'b1;
      res_i       = (n_acc < len) ? stim[n_acc] : 64'hDEAD_BEEF_0BAD_F00D;
      case (ready_mode)
        0: pack_ready_i = 1'b1;
        1: pack_ready_i = 1'($urandom_range(0, 1));
        default: begin
          if (pack_valid_o && stall_left > 0) begin
            pack_ready_i = 1'b0; stall_left--;
          end else pack_ready_i = 1'b1;
        end
      endcase
      @(negedge clk_i);
      if (cyc == 0) begin
        checks++;
        if (busy_o !== 1'b1) begin
          errors++; $display("FAIL busy_rise: busy_o=%b, required 1", busy_o);
        end
      end
      if (exp_valid) begin
        checks++;
        if (pack_valid_o !== 1'b1) begin
          errors++; $display("FAIL word_latency: pack_valid_o=%b, required 1", pack_valid_o);
        end
      end
      if (done_o) begin
        checks++;
        if (busy_o !== 1'b0) begin
          errors++; $display("FAIL busy_fall_with_done: busy_o=%b, required 0", busy_o);
        end
      end
      exp_valid = 0;
      if (n_acc >= len && res_valid_i) begin
        checks++;
        if (res_ready_o !== 1'b0) begin
          errors++; $display("FAIL extra_accept: res_ready_o=%b, required 0", res_ready_o);
        end
      end else if (res_valid_i && res_ready_o) begin
        if (((n_acc + 1) % PF == 0) || (n_acc + 1 == len)) exp_valid = 1;
        n_acc++;
        acc_cycles = cyc + 1;
      end
      @(posedge clk_i); #1;
      cyc++;
    end
    res_valid_i  = 1'b0;
    start_i      = 1'b0;
    pack_ready_i = 1'b1;
    timed_out    = (done_cnt == dbase);
  endtask

  task automatic test_stream(input string name, input int len, input int mode, input bit gaps, input bit inject);
    int acc_cyc, n_acc, nw, dbase;
    bit to;
    dbase = done_cnt;
    run_stream(len, mode, gaps, inject, acc_cyc, n_acc, to);
    checks++;
    if (to) begin errors++; $display("FAIL %s_timeout: done not seen, required done", name); end
    checks++;
    if (n_acc != len) begin errors++; $display("FAIL %s_accepts: got %0d, required %0d", name, n_acc, len); end
    nw = (len + PF - 1) / PF;
    checks++;
    if (got_data.size() != nw) begin
      errors++; $display("FAIL %s_word_count: got %0d, required %0d", name, got_data.size(), nw);
    end
    for (int w = 0; w < got_data.size() && w < nw; w++) begin
      checks++;
      if (got_data[w] !== exp_word(w, len) || got_strb[w] !== exp_strb(w, len)) begin
        errors++;
        $display("FAIL %s_word%0d: got %h/%b, required %h/%b", name, w, got_data[w], got_strb[w],
                 exp_word(w, len), exp_strb(w, len));
      end
    end
    repeat (2) @(posedge clk_i);
    #1;
    checks++;
    if (done_cnt - dbase != 1) begin
      errors++; $display("FAIL %s_done_pulses: got %0d, required 1", name, done_cnt - dbase);
    end
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL %s_busy_end: busy_o=%b, required 0", name, busy_o); end
    if (mode == 0 && !gaps) begin
      checks++;
      if (acc_cyc != len) begin
        errors++; $display("FAIL %s_throughput: %0d cycles, required %0d", name, acc_cyc, len);
      end
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    checks++;
    if ({res_ready_o, pack_valid_o, busy_o, done_o} !== 4'b0 || pack_o !== '0 || pack_strb_o !== '0) begin
      errors++;
      $display("FAIL reset_values: rdy=%b val=%b busy=%b done=%b pack=%h strb=%b, required all 0",
               res_ready_o, pack_valid_o, busy_o, done_o, pack_o, pack_strb_o);
    end
    rst_ni = 1'b1;
    @(negedge clk_i);
    checks++;
    if ({res_ready_o, pack_valid_o, busy_o, done_o} !== 4'b0) begin
      errors++; $display("FAIL reset_release: flags=%b, required 0000", {res_ready_o, pack_valid_o, busy_o, done_o});
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_full_word();
    logic [PW-1:0] ref_w;
    stim.delete();
    for (int i = 0; i < 4; i++) stim.push_back(DW'(i + 1));
    test_stream("full_word", 4, 0, 0, 0);
    ref_w = {64'd4, 64'd3, 64'd2, 64'd1};
    checks++;
    if (got_data.size() < 1 || got_data[0] !== ref_w || got_strb[0] !== 4'b1111) begin
      errors++; $display("FAIL full_word_lanes: required %h strobe 1111", ref_w);
    end
  endtask

  task automatic test_partial();
    stim.delete();
    for (int i = 10; i < 16; i++) stim.push_back(DW'(i));
    test_stream("partial", 6, 0, 0, 0);
    checks++;
    if (got_strb.size() != 2 || got_strb[1] !== 4'b0011 || got_data[1] !== {64'd0, 64'd0, 64'd15, 64'd14}) begin
      errors++; $display("FAIL partial_last_word: %0d words, required 2 ending {0,0,15,14}/0011", got_strb.size());
    end
  endtask

  task automatic test_backpressure();
    int sbase;
    stim.delete();
    for (int i = 0; i < 8; i++) stim.push_back(DW'(i));
    sbase = stall_cnt;
    test_stream("backpressure", 8, 2, 0, 0);
    checks++;
    if (stall_cnt - sbase < 5) begin
      errors++; $display("FAIL backpressure_stalls: got %0d stall cycles, required >= 5", stall_cnt - sbase);
    end
  endtask

  task automatic test_zero_len();
    int dbase;
    dbase = done_cnt;
    got_data.delete(); got_strb.delete();
    res_valid_i = 1'b1; pack_ready_i = 1'b1; start_i = 1'b1; len_i = '0;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (done_o !== 1'b1 || busy_o !== 1'b0 || res_ready_o !== 1'b0) begin
      errors++; $display("FAIL zero_len_done: done=%b busy=%b rdy=%b, required 1 0 0", done_o, busy_o, res_ready_o);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      checks++;
      if (done_o !== 1'b0 || pack_valid_o !== 1'b0 || res_ready_o !== 1'b0) begin
        errors++; $display("FAIL zero_len_quiet: done=%b val=%b rdy=%b, required 0 0 0", done_o, pack_valid_o, res_ready_o);
      end
    end
    checks++;
    if (done_cnt - dbase != 1 || got_data.size() != 0) begin
      errors++; $display("FAIL zero_len_counts: done %0d words %0d, required 1 and 0", done_cnt - dbase, got_data.size());
    end
    res_valid_i = 1'b0;
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset_mid_run();
    int n, cyc;
    stim.delete();
    for (int i = 0; i < 8; i++) stim.push_back({$urandom, $urandom});
    start_i = 1'b1; len_i = CW'(8); pack_ready_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0; res_valid_i = 1'b1; n = 0; cyc = 0;
    while (n < 3 && cyc < 50) begin
      res_i = stim[n];
      @(negedge clk_i);
      if (res_valid_i && res_ready_o) n++;
      @(posedge clk_i); #1;
      cyc++;
    end
    res_valid_i = 1'b0;
    checks++;
    if (n != 3 || busy_o !== 1'b1) begin
      errors++; $display("FAIL mid_run_setup: accepted %0d busy=%b, required 3 and 1", n, busy_o);
    end
    #2 rst_ni = 1'b0;
    #1;
    checks++;
    if ({res_ready_o, pack_valid_o, busy_o, done_o} !== 4'b0 || pack_o !== '0 || pack_strb_o !== '0) begin
      errors++; $display("FAIL mid_run_reset: flags=%b pack=%h, required all 0", {res_ready_o, pack_valid_o, busy_o, done_o}, pack_o);
    end
    @(posedge clk_i); #3;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    stim.delete();
    for (int i = 0; i < 4; i++) stim.push_back({$urandom, $urandom});
    test_stream("after_reset", 4, 0, 0, 0);
  endtask

  task automatic test_start_while_busy();
    stim.delete();
    for (int i = 0; i < 4; i++) stim.push_back({$urandom, $urandom});
    test_stream("start_busy", 4, 0, 0, 1);
  endtask

  task automatic test_random_runs();
    int len;
    for (int r = 0; r < 8; r++) begin
      len = $urandom_range(1, 13);
      stim.delete();
      for (int i = 0; i < len; i++) stim.push_back({$urandom, $urandom});
      test_stream($sformatf("random%0d", r), len, $urandom_range(0, 2), 1'($urandom_range(0, 1)), 0);
    end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_partial();
    test_backpressure();
    test_zero_len();
    test_reset_mid_run();
    test_start_while_busy();
    test_random_runs();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_snax_alu_result_packer

`default_nettype wire

// File: doc/snax_alu_result_packer.md
# snax_alu_result_packer

Receives the scalar result stream (`c`, valid/ready) produced by the SNAX ALU processing element. Packs `PackFactor` consecutive results into one wide word and presents it on a valid/ready output toward the streamer or TCDM write path. A run is started by a CSR-driven start pulse carrying the expected result count. The block flushes a partially filled final word and signals completion with a one-cycle `done_o`.

## Interface
- `DataWidth`, 64, width of one ALU result
- `PackFactor`, 4, results per packed word (power of two, ≥2)
- `CountWidth`, 16, width of the result-count registers
- `clk_i`  in  1  clock; all logic on its rising edge
- `rst_ni`  in  1  reset; asynchronous, active-low
- `start_i`  in  1  start pulse; sampled only in IDLE
- `len_i`  in  CountWidth  number of results in the run; sampled with `start_i`
- `res_i`  in  DataWidth  result data from the PE
- `res_valid_i`  in  1  result valid
- `res_ready_o`  out  1  result accepted when high together with `res_valid_i`
- `pack_o`  out  DataWidth*PackFactor  packed word; lane k is at bits [k*DataWidth +: DataWidth]
- `pack_strb_o`  out  PackFactor  per-lane valid mask
- `pack_valid_o`  out  1  packed word valid
- `pack_ready_i`  in  1  downstream ready
- `busy_o`  out  1  high whenever the state is not IDLE
- `done_o`  out  1  one-cycle completion pulse

## Operation
- **States:** IDLE, COLLECT, DRAIN.
- **IDLE**
  - `start_i` with `len_i != 0`: latch `len_i`, clear the received count and the lane index, go to COLLECT.
  - `start_i` with `len_i == 0`: pulse `done_o` on the next cycle and stay in IDLE.
- **COLLECT**
  - `res_ready_o` = `!(pack_valid_o && !pack_ready_i)`. The block stalls while the output register is occupied and not draining this cycle.
  - On an accepted result: write it into lane `lane_idx` of the fill buffer, set the matching bit of the fill mask, increment `lane_idx` modulo `PackFactor`, and increment the received count.
  - A word is complete when `lane_idx == PackFactor-1` or the result is the last one (received count equals len-1). On completion:
    - transfer the fill buffer and mask to the output register and set `pack_valid_o`;
    - clear the fill buffer to zero.
  - After the last accept, go to DRAIN.
- **DRAIN**
  - `res_ready_o` = 0.
  - When the output handshake completes (`pack_valid_o && pack_ready_i`), go to IDLE and pulse `done_o` on the next cycle.
- **Output register**
  - Holds its value while `pack_valid_o && !pack_ready_i`.
  - Cleared to zero, with `pack_valid_o` = 0, on a handshake that has no simultaneous new word.
- **Partial final word:** unused upper lanes are zero and their `pack_strb_o` bits are 0.
- **Start while busy:** `start_i` outside IDLE is ignored and `len_i` is not re-sampled.
- **Counter widths:** the received count never exceeds len, so no wrap is possible. `len_i` maximum is 2^CountWidth-1.
- **Extra results:** results arriving in IDLE or DRAIN are not accepted because `res_ready_o` = 0.

## Timing
- **Reset values:** `res_ready_o`, `pack_valid_o`, `busy_o` and `done_o` are 0. `pack_o` and `pack_strb_o` are all-zero. State is IDLE.
- **Reset mid-run:** asserting `rst_ni` low clears everything immediately, including any pending output word, which is lost. The next start after reset behaves normally.
- **Data path latency:** `pack_valid_o` rises the cycle after the accept that completes a word.
- **Throughput:** with `pack_ready_i` held high, one result is accepted every cycle with no bubbles.
- **Simultaneous events:** a handshake on the output and completion of a new word in the same cycle load the new word, and `pack_valid_o` stays high.
- **`busy_o`:** rises the cycle after `start_i`. Falls in the same cycle `done_o` rises.
- **`done_o` timing:**
  - `len_i == 0`: `done_o` comes exactly 1 cycle after start.
  - Otherwise: `done_o` comes 1 cycle after the final output handshake.
- **Output stability:** `pack_o` and `pack_strb_o` are stable while `pack_valid_o && !pack_ready_i`.

## Structure
- **Package `snax_alu_pkg` contains:**
  - the `packer_state_e` enum (IDLE, COLLECT, DRAIN);
  - default `DataWidth` and `PackFactor` constants, shared with the PE and its CSR manager.
- **No sub-module:** the fill buffer, output register and FSM are small and live inline.

## Test plan
- **Full word:** `len_i` = 4, results 1, 2, 3, 4 back-to-back, `pack_ready_i` = 1. Expect one word with lanes {4,3,2,1} and `pack_strb_o` = 1111, then `done_o` for one cycle, then `busy_o` = 0.
- **Partial final word:** `len_i` = 6, results 10..15. Expect word 1 = {13,12,11,10} with strobe 1111. Expect word 2 = {0,0,15,14} with strobe 0011. Expect exactly two `pack_valid_o` handshakes.
- **Backpressure:** `len_i` = 8 with `pack_ready_i` held low for 5 cycles after the first word. Expect `pack_o` held stable and `res_ready_o` low during the stall, no result lost or duplicated, and final words {3,2,1,0} and {7,6,5,4} when results are 0..7.
- **Zero length:** `len_i` = 0 with `start_i`. Expect `done_o` = 1 on the next cycle only, `pack_valid_o` never rising, and `res_ready_o` staying 0.
- **Reset mid-run:** `len_i` = 8, 3 results accepted, then `rst_ni` pulsed low. Expect all outputs at their reset values immediately. A following run with `len_i` = 4 produces a correct single word.
- **Start while busy:** a second `start_i` with `len_i` = 2 during COLLECT of a `len_i` = 4 run is ignored. Exactly 4 results are packed and a single `done_o` pulse occurs.
